apb_slave_regfile: RTL

APB4 completer, the responder side of the team's APB master. It decodes word-aligned accesses into a bank of NUM_REGS 32-bit registers and inserts a programmable number of wait states. It also flags errors on PSLVERR. Read-write registers are exported to the core; read-only registers are sourced from core status inputs.

---
 rtl/apb_slave_regfile.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB4 completer fronting a bank of NUM_REGS 32-bit registers.
// Adds WAIT_CYCLES wait states to every access phase. Misaligned, out-of-range and
// read-only writes are flagged on pslverr. Read-only slots are sourced from ro_in.
module apb_slave_regfile #(
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [31:0]                paddr,
    input  logic [31:0]                pwdata,
    input  logic [3:0]                 pstrb,
    output logic [31:0]                prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [32*NUM_REGS-1:0]     reg_q,
    input  logic [32*NUM_REGS-1:0]     ro_in,
    output logic [NUM_REGS-1:0]        wr_pulse
);
    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic { IDLE, ACCESS } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [31:0]      regs [NUM_REGS];

    logic [IDX_W-1:0] idx;
    logic             addr_ok;
    logic             is_ro;
    logic             xfer;
    logic             err;
    logic             wr_ok;
    logic [31:0]      rd_val;

    // Word index plus range check: every address bit above the register window must be zero.
    assign idx     = paddr[2 +: IDX_W];
    assign addr_ok = (paddr[1:0] == 2'b00) && (paddr[31:IDX_W+2] == '0);
    assign is_ro   = RO_MASK[idx];

    // The transfer completes in the ACCESS cycle where the wait counter has drained.
    assign pready  = (state == ACCESS) && (cnt == 4'd0);
    assign xfer    = pready && psel && penable;

    // Reads only fail on decode; writes also fail on read-only targets.
    assign err     = !addr_ok || (pwrite && is_ro);
    assign wr_ok   = xfer && pwrite && !err && (pstrb != 4'b0000);

    assign rd_val  = is_ro ? ro_in[32*idx +: 32] : regs[idx];
    assign pslverr = xfer && err;
    assign prdata  = (xfer && !pwrite && addr_ok) ? rd_val : 32'd0;

    // State and wait-counter register; reset returns the bus interface to IDLE.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: setup loads the wait count, which drains during enabled access cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (penable) begin
                    if (cnt == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register bank with byte strobes and a one-cycle write notification per register.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_ok) begin
                for (int k = 0; k < 4; k++) begin
                    if (pstrb[k]) begin
                        regs[idx][8*k +: 8] <= pwdata[8*k +: 8];
                    end
                end
                wr_pulse[idx] <= 1'b1;
            end
        end
    end

    // Export the bank: read-only slots mirror their status inputs.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[32*i +: 32] = RO_MASK[i] ? ro_in[32*i +: 32] : regs[i];
    end

endmodule
